// File: rtl/battle_pkg.sv
// Shared definitions for the battle sequencer: state encodings and HP arithmetic.
package battle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DODGE  = 3'd1,
    ST_MENU   = 3'd2,
    ST_ATTACK = 3'd3,
    ST_WIN    = 3'd4,
    ST_LOSE   = 3'd5
  } state_t;

  // HP never wraps: damage at or above the remaining HP leaves exactly zero.
  function automatic logic [15:0] sat_sub(input logic [15:0] hp, input logic [15:0] dmg);
    return (hp <= dmg) ? 16'd0 : hp - dmg;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable down-counter advanced by the frame strobe; sticks at zero and flags it.
module frame_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (tick && (cnt != '0))
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/battle_sequencer.sv
// Turn-based battle controller: dodge/menu/attack sequencing, HP registers,
// hit acceptance with an invulnerability window.
module battle_sequencer
  import battle_pkg::*;
#(
  parameter logic [15:0] PLAYER_HP     = 16'd300,
  parameter logic [15:0] MONSTER_HP    = 16'd500,
  parameter logic [15:0] HIT_DAMAGE    = 16'd10,
  parameter logic [15:0] ATTACK_DAMAGE = 16'd50,
  parameter logic [15:0] DODGE_FRAMES  = 16'd600,
  parameter logic [7:0]  INVULN_FRAMES = 8'd30
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_frame,
  input  logic        i_hit,
  input  logic        i_start,
  input  logic        i_attack,
  output logic [15:0] o_player_hp,
  output logic [15:0] o_monster_hp,
  output logic        o_balls_en,
  output logic        o_invuln,
  output logic [2:0]  o_state,
  output logic        o_done,
  output logic        o_win
);

  state_t      state, state_nxt;
  logic [15:0] php, php_nxt, mhp, mhp_nxt;
  logic        hit_seen, hit_seen_nxt, hit_now;
  logic        dod_load, dod_tick, dod_zero;
  logic        inv_load, inv_tick, inv_zero;
  logic [7:0]  inv_val;

  // Loaded with one less than the length so the zero flag marks the final frame.
  frame_timer #(.W(16)) u_dodge (
    .clk(i_clk), .rst_n(i_rst_n), .load(dod_load),
    .load_val(DODGE_FRAMES - 16'd1), .tick(dod_tick), .zero(dod_zero)
  );

  frame_timer #(.W(8)) u_invuln (
    .clk(i_clk), .rst_n(i_rst_n), .load(inv_load),
    .load_val(inv_val), .tick(inv_tick), .zero(inv_zero)
  );

  always_comb begin
    state_nxt    = state;
    php_nxt      = php;
    mhp_nxt      = mhp;
    hit_seen_nxt = 1'b0;
    hit_now      = 1'b0;
    dod_load     = 1'b0;
    dod_tick     = 1'b0;
    inv_load     = 1'b0;
    inv_tick     = 1'b0;
    inv_val      = INVULN_FRAMES;
    case (state)
      ST_IDLE: begin
        php_nxt = PLAYER_HP;
        mhp_nxt = MONSTER_HP;
        if (i_start) begin
          state_nxt = ST_DODGE;
          dod_load  = 1'b1;
          inv_load  = 1'b1;
          inv_val   = 8'd0;
        end
      end
      ST_DODGE: begin
        if (i_frame) begin
          // A hit arriving on the strobe cycle itself still belongs to this frame.
          hit_now  = hit_seen | i_hit;
          dod_tick = 1'b1;
          if (inv_zero && hit_now) begin
            php_nxt  = sat_sub(php, HIT_DAMAGE);
            inv_load = 1'b1;
          end else begin
            inv_tick = 1'b1;
          end
          if (php_nxt == 16'd0)
            state_nxt = ST_LOSE;
          else if (dod_zero)
            state_nxt = ST_MENU;
        end else begin
          hit_seen_nxt = hit_seen | i_hit;
        end
      end
      ST_MENU: begin
        inv_tick = i_frame;
        if (i_attack)
          state_nxt = ST_ATTACK;
      end
      ST_ATTACK: begin
        mhp_nxt = sat_sub(mhp, ATTACK_DAMAGE);
        if (mhp_nxt == 16'd0) begin
          state_nxt = ST_WIN;
        end else begin
          state_nxt = ST_DODGE;
          dod_load  = 1'b1;
        end
      end
      ST_WIN, ST_LOSE: begin
        if (i_start) begin
          php_nxt   = PLAYER_HP;
          mhp_nxt   = MONSTER_HP;
          state_nxt = ST_DODGE;
          dod_load  = 1'b1;
          inv_load  = 1'b1;
          inv_val   = 8'd0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      php        <= PLAYER_HP;
      mhp        <= MONSTER_HP;
      hit_seen   <= 1'b0;
      o_balls_en <= 1'b0;
      o_done     <= 1'b0;
      o_win      <= 1'b0;
    end else begin
      state      <= state_nxt;
      php        <= php_nxt;
      mhp        <= mhp_nxt;
      hit_seen   <= hit_seen_nxt;
      o_balls_en <= (state_nxt == ST_DODGE);
      o_done     <= (state_nxt == ST_WIN) || (state_nxt == ST_LOSE);
      o_win      <= (state_nxt == ST_WIN);
    end
  end

  assign o_player_hp  = php;
  assign o_monster_hp = mhp;
  assign o_state      = state;
  assign o_invuln     = !inv_zero;

endmodule

// File: tb/tb_battle_sequencer.sv
// Bench for battle_sequencer: three parameterisations checked every cycle
// against a frame-level reference model, plus scripted literal checkpoints.
module tb_battle_sequencer;

  typedef struct packed {
    int st;
    int php;
    int mhp;
    int fcnt;
    int inv;
    bit hs;
  } mdl_t;

  logic        clk = 1'b0;
  logic        rst_n [3];
  logic        frm   [3];
  logic        hit   [3];
  logic        start [3];
  logic        atk   [3];
  logic [15:0] ophp  [3];
  logic [15:0] omhp  [3];
  logic        obal  [3];
  logic        oinv  [3];
  logic [2:0]  ost   [3];
  logic        odone [3];
  logic        owin  [3];

  mdl_t m [3];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  battle_sequencer u0 (
    .i_clk(clk), .i_rst_n(rst_n[0]), .i_frame(frm[0]), .i_hit(hit[0]),
    .i_start(start[0]), .i_attack(atk[0]), .o_player_hp(ophp[0]),
    .o_monster_hp(omhp[0]), .o_balls_en(obal[0]), .o_invuln(oinv[0]),
    .o_state(ost[0]), .o_done(odone[0]), .o_win(owin[0])
  );

  battle_sequencer #(.PLAYER_HP(16'd10)) u1 (
    .i_clk(clk), .i_rst_n(rst_n[1]), .i_frame(frm[1]), .i_hit(hit[1]),
    .i_start(start[1]), .i_attack(atk[1]), .o_player_hp(ophp[1]),
    .o_monster_hp(omhp[1]), .o_balls_en(obal[1]), .o_invuln(oinv[1]),
    .o_state(ost[1]), .o_done(odone[1]), .o_win(owin[1])
  );

  battle_sequencer #(.PLAYER_HP(16'd5), .MONSTER_HP(16'd100), .DODGE_FRAMES(16'd8),
                     .INVULN_FRAMES(8'd3)) u2 (
    .i_clk(clk), .i_rst_n(rst_n[2]), .i_frame(frm[2]), .i_hit(hit[2]),
    .i_start(start[2]), .i_attack(atk[2]), .o_player_hp(ophp[2]),
    .o_monster_hp(omhp[2]), .o_balls_en(obal[2]), .o_invuln(oinv[2]),
    .o_state(ost[2]), .o_done(odone[2]), .o_win(owin[2])
  );

  // Reference model: one call advances a battle by one clock cycle.
  function automatic mdl_t step(mdl_t s, int i, bit rn, bit f, bit h, bit go, bit a);
    int ph, mh, df, ifr;
    bit hn;
    ph = (i == 0) ? 300 : (i == 1) ? 10 : 5;
    mh = (i == 2) ? 100 : 500;
    df = (i == 2) ? 8 : 600;
    ifr = (i == 2) ? 3 : 30;
    if (!rn) begin
      s.st = 0; s.php = ph; s.mhp = mh; s.fcnt = 0; s.inv = 0; s.hs = 0;
      return s;
    end
    case (s.st)
      0: if (go) begin s.st = 1; s.fcnt = 0; s.inv = 0; s.hs = 0; end
      1: begin
        if (f) begin
          hn = s.hs | h;
          s.hs = 0;
          if (s.inv == 0 && hn) begin
            s.php = (s.php <= 10) ? 0 : s.php - 10;
            s.inv = ifr;
          end else if (s.inv > 0) begin
            s.inv = s.inv - 1;
          end
          s.fcnt = s.fcnt + 1;
          if (s.php == 0) s.st = 5;
          else if (s.fcnt == df) s.st = 2;
        end else if (h) begin
          s.hs = 1;
        end
      end
      2: begin
        s.hs = 0;
        if (f && s.inv > 0) s.inv = s.inv - 1;
        if (a) s.st = 3;
      end
      3: begin
        s.mhp = (s.mhp <= 50) ? 0 : s.mhp - 50;
        if (s.mhp == 0) s.st = 4;
        else begin s.st = 1; s.fcnt = 0; end
      end
      default: if (go) begin
        s.php = ph; s.mhp = mh; s.st = 1; s.fcnt = 0; s.inv = 0; s.hs = 0;
      end
    endcase
    return s;
  endfunction

  always @(posedge clk)
    for (int i = 0; i < 3; i++)
      m[i] = step(m[i], i, rst_n[i], frm[i], hit[i], start[i], atk[i]);

  task automatic chk(input string nm, input int i, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[u%0d] at %0t: got %0d, expected %0d", nm, i, $time, act, exp);
    end
  endtask

  always @(negedge clk)
    for (int i = 0; i < 3; i++) begin
      chk("state", i, int'(ost[i]), m[i].st);
      chk("player_hp", i, int'(ophp[i]), m[i].php);
      chk("monster_hp", i, int'(omhp[i]), m[i].mhp);
      chk("balls_en", i, int'(obal[i]), int'(m[i].st == 1));
      chk("invuln", i, int'(oinv[i]), int'(m[i].inv != 0));
      chk("done", i, int'(odone[i]), int'(m[i].st == 4 || m[i].st == 5));
      chk("win", i, int'(owin[i]), int'(m[i].st == 4));
    end

  task automatic cyc();
    @(posedge clk);
    #3;
  endtask

  task automatic frames(input int i, input int n, input bit h);
    for (int k = 0; k < n; k++) begin
      frm[i] = 1'b1; hit[i] = h; cyc();
      frm[i] = 1'b0; cyc();
    end
    hit[i] = 1'b0;
  endtask

  task automatic pulse_start(input int i);
    start[i] = 1'b1; cyc(); start[i] = 1'b0;
  endtask

  task automatic pulse_atk(input int i);
    atk[i] = 1'b1; cyc(); atk[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; frm[i] = 1'b0; hit[i] = 1'b0; start[i] = 1'b0; atk[i] = 1'b0;
    end
    atk[0] = 1'b1;
    repeat (3) cyc();
    atk[0] = 1'b0;
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    cyc();
    chk("lit_rst_state", 0, int'(ost[0]), 0);
    chk("lit_rst_php", 0, int'(ophp[0]), 300);
    chk("lit_rst_mhp", 0, int'(omhp[0]), 500);
    chk("lit_rst_done", 0, int'(odone[0]), 0);

    // Attack in IDLE is ignored; start enters DODGE
    pulse_atk(0);
    chk("lit_idle_atk", 0, int'(ost[0]), 0);
    pulse_start(0);
    chk("lit_start_state", 0, int'(ost[0]), 1);
    chk("lit_start_balls", 0, int'(obal[0]), 1);
    frames(0, 300, 1'b0);
    pulse_atk(0);
    pulse_start(0);
    chk("lit_ignored_state", 0, int'(ost[0]), 1);
    frames(0, 300, 1'b0);
    chk("lit_menu_state", 0, int'(ost[0]), 2);
    chk("lit_menu_balls", 0, int'(obal[0]), 0);
    chk("lit_menu_php", 0, int'(ophp[0]), 300);
    frames(0, 5, 1'b1);
    chk("lit_menu_hit", 0, int'(ophp[0]), 300);

    // Ten attacks defeat the monster; the first dodge round carries the hit test
    for (int k = 0; k < 10; k++) begin
      pulse_atk(0);
      chk("lit_attack_state", 0, int'(ost[0]), 3);
      cyc();
      chk("lit_attack_mhp", 0, int'(omhp[0]), 450 - 50 * k);
      if (k == 9) break;
      if (k == 0) begin
        frames(0, 1, 1'b1);
        chk("lit_hit1_php", 0, int'(ophp[0]), 290);
        chk("lit_hit1_inv", 0, int'(oinv[0]), 1);
        frames(0, 30, 1'b1);
        chk("lit_inv_php", 0, int'(ophp[0]), 290);
        chk("lit_inv_end", 0, int'(oinv[0]), 0);
        frames(0, 1, 1'b1);
        chk("lit_hit2_php", 0, int'(ophp[0]), 280);
        frames(0, 8, 1'b1);
        frames(0, 560, 1'b0);
      end else begin
        frames(0, 600, 1'b0);
      end
      chk("lit_round_menu", 0, int'(ost[0]), 2);
    end
    chk("lit_win_state", 0, int'(ost[0]), 4);
    chk("lit_win_flag", 0, int'(owin[0]), 1);
    chk("lit_win_php", 0, int'(ophp[0]), 280);

    // Restart from WIN, take three hits, then reset mid-dodge with a hit pending
    pulse_start(0);
    chk("lit_restart_php", 0, int'(ophp[0]), 300);
    chk("lit_restart_mhp", 0, int'(omhp[0]), 500);
    frames(0, 1, 1'b1);
    frames(0, 98, 1'b0);
    frames(0, 1, 1'b1);
    frames(0, 179, 1'b0);
    frames(0, 1, 1'b1);
    frames(0, 20, 1'b0);
    chk("lit_mid_php", 0, int'(ophp[0]), 270);
    chk("lit_mid_inv", 0, int'(oinv[0]), 1);
    hit[0] = 1'b1; cyc(); hit[0] = 1'b0;
    rst_n[0] = 1'b0; cyc();
    chk("lit_rst2_state", 0, int'(ost[0]), 0);
    chk("lit_rst2_php", 0, int'(ophp[0]), 300);
    chk("lit_rst2_inv", 0, int'(oinv[0]), 0);
    rst_n[0] = 1'b1;
    pulse_start(0);
    frames(0, 1, 1'b0);
    chk("lit_pending_gone", 0, int'(ophp[0]), 300);

    // Hit on the last dodge frame: damage first, LOSE beats MENU
    pulse_start(1);
    frames(1, 599, 1'b0);
    frm[1] = 1'b1; hit[1] = 1'b1; cyc();
    frm[1] = 1'b0; hit[1] = 1'b0;
    chk("lit_lose_state", 1, int'(ost[1]), 5);
    chk("lit_lose_php", 1, int'(ophp[1]), 0);
    chk("lit_lose_win", 1, int'(owin[1]), 0);
    cyc();
    pulse_start(1);
    chk("lit_relose_php", 1, int'(ophp[1]), 10);
    frames(1, 3, 1'b0);

    // Saturation from 5 HP, then randomized traffic
    pulse_start(2);
    frames(2, 1, 1'b1);
    chk("lit_sat_php", 2, int'(ophp[2]), 0);
    chk("lit_sat_state", 2, int'(ost[2]), 5);
    for (int k = 0; k < 4000; k++) begin
      rst_n[2] = ($urandom_range(0, 299) != 0);
      frm[2]   = ($urandom_range(0, 2) == 0);
      hit[2]   = ($urandom_range(0, 3) == 0);
      start[2] = ($urandom_range(0, 19) == 0);
      atk[2]   = ($urandom_range(0, 3) == 0);
      cyc();
    end
    rst_n[2] = 1'b1; frm[2] = 1'b0; hit[2] = 1'b0; start[2] = 1'b0; atk[2] = 1'b0;
    cyc();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
